uart_mmio_fifo: RTL

Memory-mapped dual-channel UART byte buffer sitting between the processor data bus and the UART receiver/transmitter. It holds an RX FIFO filled by the UART receiver and drained by CPU loads, and a TX FIFO filled by CPU stores and drained by the UART transmitter. It adds status and control registers, occupancy counts, sticky RX overrun, flush and an optional interrupt. Depth and data width are parameters.

---
 rtl/uart_mmio_fifo_if.sv | 18 +
 rtl/uart_mmio_fifo.sv | 99 +++++++++
 2 files changed

// File: rtl/uart_mmio_fifo_if.sv
// uart_mmio_fifo_if: CPU bus and UART-side signals of uart_mmio_fifo
interface uart_mmio_fifo_if #(parameter int DATA_W = 8);
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic buf_read_i, buf_write_i, sel_o;
  logic [DATA_W-1:0] rx_data_i, tx_data_o;
  logic rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i;
  logic rx_empty_o, rx_full_o, tx_empty_o, tx_full_o, irq_o;
  modport slave (
    input addr_i, wdata_i, buf_read_i, buf_write_i, rx_data_i, rx_valid_i, tx_ready_i,
    output rdata_o, sel_o, rx_ready_o, tx_data_o, tx_valid_o, rx_empty_o, rx_full_o,
    tx_empty_o, tx_full_o, irq_o
  );
  modport master (
    output addr_i, wdata_i, buf_read_i, buf_write_i, rx_data_i, rx_valid_i, tx_ready_i,
    input rdata_o, sel_o, rx_ready_o, tx_data_o, tx_valid_o, rx_empty_o, rx_full_o,
    tx_empty_o, tx_full_o, irq_o
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped RX/TX byte FIFOs with status/control registers.
// Interrupt output and CTRL enable bits exist only when UART_MMIO_FIFO_IRQ_EN is defined.
module uart_mmio_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 7,
  parameter int AF_LVL = 3 * (2 ** DEPTH_LOG2) / 4
) (
  input logic clk,
  input logic rst_n_i,
  uart_mmio_fifo_if.slave bus
);
  localparam int P = DEPTH_LOG2 + 1;
  localparam int D = 2 ** DEPTH_LOG2;
  localparam logic [31:0] DB = 32'hdeadbeef;
  logic [DATA_W-1:0] rx_mem [D];
  logic [DATA_W-1:0] tx_mem [D];
  logic [P-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr, rx_count, tx_count;
  logic [DEPTH_LOG2-1:0] rx_widx, rx_ridx, tx_widx, tx_ridx;
  logic rx_empty, rx_full, tx_empty, tx_full, rx_af, overrun;
  logic sel, rd, wr, rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush, status_wr, ctrl_wr;
  logic [1:0] reg_sel, irq_en;
  logic [31:0] status, rd_val, rdata;
  logic unused;
  assign sel = bus.addr_i[18:16] == 3'h1 && (bus.buf_read_i || bus.buf_write_i);
  assign reg_sel = bus.addr_i[3:2];
  assign rd = sel && bus.buf_read_i;
  assign wr = sel && bus.buf_write_i;
  assign rx_widx = rx_wptr[DEPTH_LOG2-1:0];
  assign rx_ridx = rx_rptr[DEPTH_LOG2-1:0];
  assign tx_widx = tx_wptr[DEPTH_LOG2-1:0];
  assign tx_ridx = tx_rptr[DEPTH_LOG2-1:0];
  assign rx_count = rx_wptr - rx_rptr;
  assign tx_count = tx_wptr - tx_rptr;
  assign rx_empty = rx_wptr == rx_rptr;
  assign tx_empty = tx_wptr == tx_rptr;
  assign rx_full = rx_widx == rx_ridx && rx_wptr[DEPTH_LOG2] != rx_rptr[DEPTH_LOG2];
  assign tx_full = tx_widx == tx_ridx && tx_wptr[DEPTH_LOG2] != tx_rptr[DEPTH_LOG2];
  assign rx_af = int'(rx_count) >= AF_LVL;
  assign rx_push = bus.rx_valid_i && !rx_full;
  assign rx_pop = rd && reg_sel == 2'd0 && !rx_empty;
  assign tx_push = wr && reg_sel == 2'd1 && !tx_full;
  assign tx_pop = bus.tx_ready_i && !tx_empty;
  assign status_wr = wr && reg_sel == 2'd2;
  assign ctrl_wr = wr && reg_sel == 2'd3;
  assign rx_flush = ctrl_wr && bus.wdata_i[8];
  assign tx_flush = ctrl_wr && bus.wdata_i[9];
  assign status = {8'h0, 8'(tx_count), 8'(rx_count), 2'b0, rx_af, overrun,
                   tx_full, tx_empty, rx_full, rx_empty};
  assign rd_val = !rd ? DB :
                  reg_sel == 2'd0 ? (rx_empty ? DB : 32'(rx_mem[rx_ridx])) :
                  reg_sel == 2'd2 ? status :
                  reg_sel == 2'd3 ? {30'h0, irq_en} : DB;
  assign unused = ^{bus.addr_i, bus.wdata_i};
  // Flush discards queued entries by catching the read pointer up; it overrides push/pop.
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
      overrun <= 1'b0;
      rdata <= 32'h0;
    end else begin
      rx_wptr <= rx_wptr + P'(rx_push && !rx_flush);
      rx_rptr <= rx_flush ? rx_wptr : rx_rptr + P'(rx_pop);
      tx_wptr <= tx_wptr + P'(tx_push && !tx_flush);
      tx_rptr <= tx_flush ? tx_wptr : tx_rptr + P'(tx_pop);
      overrun <= (bus.rx_valid_i && rx_full) || (overrun && !status_wr);
      rdata <= rd_val;
    end
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_widx] <= bus.rx_data_i;
    if (tx_push) tx_mem[tx_widx] <= bus.wdata_i[DATA_W-1:0];
  end
`ifdef UART_MMIO_FIFO_IRQ_EN
  logic irq;
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      irq_en <= 2'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus.wdata_i[1:0];
      irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty) || overrun;
    end
  assign bus.irq_o = irq;
`else
  assign irq_en = 2'b0;
  assign bus.irq_o = 1'b0;
`endif
  assign bus.rdata_o = rdata;
  assign bus.sel_o = sel;
  assign bus.rx_ready_o = !rx_full;
  assign bus.tx_data_o = tx_mem[tx_ridx];
  assign bus.tx_valid_o = !tx_empty;
  assign bus.rx_empty_o = rx_empty;
  assign bus.rx_full_o = rx_full;
  assign bus.tx_empty_o = tx_empty;
  assign bus.tx_full_o = tx_full;
endmodule
